// File: rtl/mips_pkg.sv
// Shared datapath constants and types for the write-back stage and register file.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with a hardwired zero register and a
// same-cycle write-to-read bypass so ID sees the value being committed.
module regfile_2r1w
    import mips_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int NR    = 32
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_a_o,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] regs_q [NR];
    logic [AW-1:0] raddr [2];
    logic [DW-1:0] rdata [2];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            for (int i = 0; i < NR; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != AW'(REG_ZERO))) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign raddr[0]  = raddr_a_i;
    assign raddr[1]  = raddr_b_i;
    assign rdata_a_o = rdata[0];
    assign rdata_b_o = rdata[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign rdata[gi] = (raddr[gi] == AW'(REG_ZERO))           ? '0      :
                               (we_i && (raddr[gi] == waddr_i))        ? wdata_i :
                                                                         regs_q[raddr[gi]];
        end
    endgenerate

endmodule

// File: rtl/wb_stage_regfile.sv
// Write-back stage: picks load vs ALU data, commits it to the register file,
// drives the forwarding bus and counts retired register writes.
module wb_stage_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int NREGS  = mips_pkg::NREGS,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemtoReg_in,
    input  logic              RegWrite_in,
    input  logic [DATA_W-1:0] data_out_in,
    input  logic [DATA_W-1:0] alu_out_in,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  retired_cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign wb_data = MemtoReg_in ? data_out_in : alu_out_in;
    assign wb_en   = RegWrite_in && (rd_in != ADDR_W'(REG_ZERO));
    assign wb_rd   = rd_in;

    // Wraps silently; software reading it is expected to handle rollover.
    assign cnt_d       = wb_en ? cnt_q + CNT_W'(1) : cnt_q;
    assign retired_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    regfile_2r1w #(
        .DW (DATA_W),
        .AW (ADDR_W),
        .NR (NREGS)
    ) u_regfile (
        .clk       (clk),
        .reset_i   (reset),
        .we_i      (wb_en),
        .waddr_i   (rd_in),
        .wdata_i   (wb_data),
        .raddr_a_i (rs_addr),
        .raddr_b_i (rt_addr),
        .rdata_a_o (rs_data),
        .rdata_b_o (rt_data)
    );

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Randomised and directed checks of the write-back stage against an array model.
module tb_wb_stage_regfile;

    logic        clk;
    logic        reset;
    logic        MemtoReg_in;
    logic        RegWrite_in;
    logic [31:0] data_out_in;
    logic [31:0] alu_out_in;
    logic [4:0]  rd_in;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data, rt_data, wb_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] retired_cnt;

    logic [31:0] rs_data4, rt_data4, wb_data4;
    logic        wb_en4;
    logic [4:0]  wb_rd4;
    logic [3:0]  retired_cnt4;

    logic [31:0] model_regs [32];
    int unsigned model_cnt;
    int          n_checks;
    int          n_fail;

    wb_stage_regfile u_dut (
        .clk (clk), .reset (reset), .MemtoReg_in (MemtoReg_in), .RegWrite_in (RegWrite_in),
        .data_out_in (data_out_in), .alu_out_in (alu_out_in), .rd_in (rd_in),
        .rs_addr (rs_addr), .rt_addr (rt_addr), .rs_data (rs_data), .rt_data (rt_data),
        .wb_en (wb_en), .wb_rd (wb_rd), .wb_data (wb_data), .retired_cnt (retired_cnt)
    );

    wb_stage_regfile #(.CNT_W (4)) u_dut4 (
        .clk (clk), .reset (reset), .MemtoReg_in (MemtoReg_in), .RegWrite_in (RegWrite_in),
        .data_out_in (data_out_in), .alu_out_in (alu_out_in), .rd_in (rd_in),
        .rs_addr (rs_addr), .rt_addr (rt_addr), .rs_data (rs_data4), .rt_data (rt_data4),
        .wb_en (wb_en4), .wb_rd (wb_rd4), .wb_data (wb_data4), .retired_cnt (retired_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural view of a read: zero register, then the value being written, then storage.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (RegWrite_in && rd_in != 5'd0 && rd_in == a)
            return MemtoReg_in ? data_out_in : alu_out_in;
        return model_regs[a];
    endfunction

    task automatic drive(input logic mtr, input logic rw, input logic [31:0] dat,
                         input logic [31:0] alu, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt);
        MemtoReg_in = mtr; RegWrite_in = rw; data_out_in = dat;
        alu_out_in  = alu; rd_in = rd; rs_addr = rs; rt_addr = rt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
            model_cnt = 0;
        end else if (RegWrite_in && rd_in != 5'd0) begin
            model_regs[rd_in] = MemtoReg_in ? data_out_in : alu_out_in;
            model_cnt++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b1, $urandom, $urandom, 5'($urandom_range(1, 31)), 5'd0, 5'd0);
        tick();
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'(i), 5'(31 - i));
            n_checks += 2;
            if (rs_data !== 32'd0) begin
                n_fail++; $display("FAIL reset_rs[%0d]: got %h expected 0", i, rs_data);
            end
            if (rt_data !== 32'd0) begin
                n_fail++; $display("FAIL reset_rt[%0d]: got %h expected 0", 31 - i, rt_data);
            end
        end
        n_checks += 2;
        if (retired_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d expected 0", retired_cnt);
        end
        if (retired_cnt4 !== 4'd0) begin
            n_fail++; $display("FAIL reset_cnt4: got %0d expected 0", retired_cnt4);
        end
        $display("reset: regs 0..31 read back, cnt=%0d", retired_cnt);
    endtask

    task automatic test_alu_wb();
        logic [31:0] c0;
        c0 = model_cnt;
        drive(1'b0, 1'b1, 32'hAAAA_0000, 32'h0000_1234, 5'd5, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);
        n_checks += 2;
        if (rs_data !== 32'h0000_1234) begin
            n_fail++; $display("FAIL alu_wb_rs: got %h expected 00001234", rs_data);
        end
        if (retired_cnt !== c0 + 32'd1) begin
            n_fail++; $display("FAIL alu_wb_cnt: got %0d expected %0d", retired_cnt, c0 + 1);
        end
        $display("alu_wb: r5=%h cnt=%0d", rs_data, retired_cnt);
    endtask

    task automatic test_load_bypass();
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1111_2222, 5'd9, 5'd9, 5'd9);
        n_checks += 4;
        if (rs_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL bypass_rs: got %h expected deadbeef", rs_data);
        end
        if (rt_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL bypass_rt: got %h expected deadbeef", rt_data);
        end
        if (wb_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL bypass_wbdata: got %h expected deadbeef", wb_data);
        end
        if (wb_en !== 1'b1 || wb_rd !== 5'd9) begin
            n_fail++; $display("FAIL bypass_wbbus: got en=%b rd=%0d expected en=1 rd=9", wb_en, wb_rd);
        end
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd9, 5'd9);
        n_checks++;
        if (rs_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL load_commit: got %h expected deadbeef", rs_data);
        end
        $display("load_bypass: r9=%h", rs_data);
    endtask

    task automatic test_zero_reg();
        logic [31:0] c0;
        c0 = retired_cnt;
        drive(1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        n_checks += 2;
        if (wb_en !== 1'b0) begin
            n_fail++; $display("FAIL zero_wben: got %b expected 0", wb_en);
        end
        if (rs_data !== 32'd0) begin
            n_fail++; $display("FAIL zero_bypass: got %h expected 0", rs_data);
        end
        tick();
        n_checks += 2;
        if (rs_data !== 32'd0) begin
            n_fail++; $display("FAIL zero_read: got %h expected 0", rs_data);
        end
        if (retired_cnt !== c0) begin
            n_fail++; $display("FAIL zero_cnt: got %0d expected %0d", retired_cnt, c0);
        end
        $display("zero_reg: r0=%h cnt=%0d", rs_data, retired_cnt);
    endtask

    task automatic test_disabled();
        logic [31:0] prior;
        prior = $urandom;
        drive(1'b0, 1'b1, 32'd0, prior, 5'd7, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'h55, 5'd7, 5'd7, 5'd7);
        n_checks++;
        if (rs_data !== prior) begin
            n_fail++; $display("FAIL disabled_bypass: got %h expected %h", rs_data, prior);
        end
        tick();
        n_checks++;
        if (rt_data !== prior) begin
            n_fail++; $display("FAIL disabled_keep: got %h expected %h", rt_data, prior);
        end
        $display("disabled: r7=%h", rt_data);
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            drive(1'($urandom), ($urandom_range(0, 3) != 0), $urandom, $urandom,
                  5'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0) ? rd_in : 5'($urandom));
            n_checks += 5;
            if (rs_data !== exp_read(rs_addr)) begin
                n_fail++; $display("FAIL rand_rs[%0d]: got %h expected %h", n, rs_data, exp_read(rs_addr));
            end
            if (rt_data !== exp_read(rt_addr)) begin
                n_fail++; $display("FAIL rand_rt[%0d]: got %h expected %h", n, rt_data, exp_read(rt_addr));
            end
            if (wb_data !== (MemtoReg_in ? data_out_in : alu_out_in)) begin
                n_fail++; $display("FAIL rand_wbdata[%0d]: got %h", n, wb_data);
            end
            if (wb_en !== (RegWrite_in && rd_in != 5'd0) || wb_rd !== rd_in) begin
                n_fail++; $display("FAIL rand_wbbus[%0d]: got en=%b rd=%0d", n, wb_en, wb_rd);
            end
            if (rs_data4 !== rs_data) begin
                n_fail++; $display("FAIL rand_rs_narrow[%0d]: got %h expected %h", n, rs_data4, exp_read(rs_addr));
            end
            tick();
            n_checks += 2;
            if (retired_cnt !== model_cnt) begin
                n_fail++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", n, retired_cnt, model_cnt);
            end
            if (retired_cnt4 !== 4'(model_cnt % 16)) begin
                n_fail++; $display("FAIL rand_cnt4[%0d]: got %0d expected %0d", n, retired_cnt4, model_cnt % 16);
            end
            $display("rand %0d: rst=%b we=%b rd=%0d rs=%0d rt=%0d cnt=%0d", n, reset, RegWrite_in, rd_in, rs_addr, rt_addr, retired_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_collision();
        drive(1'b0, 1'b1, 32'd0, 32'h0BAD_F00D, 5'd3, 5'd0, 5'd0);
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b1, 32'd0, 32'h1234_5678, 5'd3, 5'd3, 5'd3);
        n_checks++;
        if (rs_data !== 32'h1234_5678) begin
            n_fail++; $display("FAIL coll_bypass: got %h expected 12345678", rs_data);
        end
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd3, 5'd3, 5'd3);
        n_checks += 2;
        if (rs_data !== 32'd0) begin
            n_fail++; $display("FAIL coll_reg3: got %h expected 0", rs_data);
        end
        if (retired_cnt !== 32'd0) begin
            n_fail++; $display("FAIL coll_cnt: got %0d expected 0", retired_cnt);
        end
        $display("reset_collision: r3=%h cnt=%0d", rs_data, retired_cnt);
    endtask

    task automatic test_cnt_wrap();
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b1, 32'd0, $urandom, 5'($urandom_range(1, 31)), 5'd0, 5'd0);
            tick();
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        n_checks += 2;
        if (retired_cnt4 !== 4'd1) begin
            n_fail++; $display("FAIL cnt_wrap4: got %0d expected 1", retired_cnt4);
        end
        if (retired_cnt !== 32'd17) begin
            n_fail++; $display("FAIL cnt_wrap32: got %0d expected 17", retired_cnt);
        end
        $display("cnt_wrap: cnt4=%0d cnt32=%0d", retired_cnt4, retired_cnt);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        model_cnt = 0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        test_reset();
        test_alu_wb();
        test_load_bypass();
        test_zero_reg();
        test_disabled();
        test_random();
        test_reset_collision();
        test_cnt_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
